// File: rtl/vga_rect_unit_pkg.sv
// Shared types and helpers for the VGA rectangle compositor (vga_pkg).
// Optional build macro VGA_TEST_PATTERN_EN is consumed by the interface and top, not here.
package vga_pkg;

  localparam int FIELD_W      = 12;
  localparam int W0_X0_LSB    = 0;
  localparam int W0_X1_LSB    = 12;
  localparam int W0_COLOR_LSB = 24;
  localparam int W1_Y0_LSB    = 0;
  localparam int W1_Y1_LSB    = 12;
  localparam int W1_EN_BIT    = 31;

  typedef struct packed {
    logic [7:0]         color;
    logic [FIELD_W-1:0] x0;
    logic [FIELD_W-1:0] x1;
    logic [FIELD_W-1:0] y0;
    logic [FIELD_W-1:0] y1;
    logic               en;
  } rect_t;

  function automatic int total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // Extract a bits-wide field whose top bit sits at msb, right-aligned.
  function automatic logic [7:0] color_field(input logic [7:0] c, input int msb, input int bits);
    logic [7:0] mask;
    mask = 8'((1 << bits) - 1);
    return (c >> (msb - bits + 1)) & mask;
  endfunction

endpackage

// File: rtl/vga_rect_unit_if.sv
// CPU-side register write port and frame status for vga_rect_unit.
// VGA_TEST_PATTERN_EN adds the vg__pattern select line.
interface vga_rect_unit_if #(
  parameter int RECTBITS = 6
);
  logic [31:0]       vg__data;
  logic [RECTBITS:0] vg__addr;
  logic              vg__write;
`ifdef VGA_TEST_PATTERN_EN
  logic              vg__pattern;
`endif
  logic              vg__vblank;
  logic              vg__frame;

`ifdef VGA_TEST_PATTERN_EN
  modport master (output vg__data, vg__addr, vg__write, vg__pattern,
                  input  vg__vblank, vg__frame);
  modport slave  (input  vg__data, vg__addr, vg__write, vg__pattern,
                  output vg__vblank, vg__frame);
`else
  modport master (output vg__data, vg__addr, vg__write,
                  input  vg__vblank, vg__frame);
  modport slave  (input  vg__data, vg__addr, vg__write,
                  output vg__vblank, vg__frame);
`endif

endinterface

// File: rtl/vga_rect_unit_timing.sv
// Pixel divider, x/y raster counters, raw sync/visible flags and bank-swap strobe.
// Unaffected by VGA_TEST_PATTERN_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 600,
  parameter int WIDTHBITS  = 11,
  parameter int HEIGHTBITS = 10,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int CLKDIV     = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  output logic                  tick,
  output logic [WIDTHBITS-1:0]  x,
  output logic [HEIGHTBITS-1:0] y,
  output logic                  visible,
  output logic                  hs_act,
  output logic                  vs_act,
  output logic                  vblank,
  output logic                  swap
);

  localparam int H_TOTAL = total(WIDTH, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(HEIGHT, V_FP, V_SYNC, V_BP);

  logic [1:0] div;
  logic       line_end;
  logic       frame_end;

  assign tick      = (div == 2'(CLKDIV - 1));
  assign line_end  = (x == WIDTHBITS'(H_TOTAL - 1));
  assign frame_end = (y == HEIGHTBITS'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else begin
      div <= tick ? 2'd0 : div + 2'd1;
      if (tick) begin
        x <= line_end ? '0 : x + WIDTHBITS'(1);
        if (line_end) y <= frame_end ? '0 : y + HEIGHTBITS'(1);
      end
    end
  end

  assign visible = (x < WIDTHBITS'(WIDTH)) && (y < HEIGHTBITS'(HEIGHT));
  assign hs_act  = (x >= WIDTHBITS'(WIDTH + H_FP)) && (x < WIDTHBITS'(WIDTH + H_FP + H_SYNC));
  assign vs_act  = (y >= HEIGHTBITS'(HEIGHT + V_FP)) && (y < HEIGHTBITS'(HEIGHT + V_FP + V_SYNC));
  assign vblank  = !(y < HEIGHTBITS'(HEIGHT));
  // Fires on the clk whose tick moves the raster to (0, HEIGHT).
  assign swap    = tick && line_end && (y == HEIGHTBITS'(HEIGHT - 1));

endmodule

// File: rtl/vga_rect_unit.sv
// VGA timing plus 2**RECTBITS double-buffered rectangles, priority-composited to RGB.
// Define VGA_TEST_PATTERN_EN to add the vg__pattern vertical-bar override.
module vga_rect_unit
  import vga_pkg::*;
#(
  parameter int         WIDTH      = 800,
  parameter int         HEIGHT     = 600,
  parameter int         WIDTHBITS  = 11,
  parameter int         HEIGHTBITS = 10,
  parameter int         H_FP       = 40,
  parameter int         H_SYNC     = 128,
  parameter int         H_BP       = 88,
  parameter int         V_FP       = 1,
  parameter int         V_SYNC     = 4,
  parameter int         V_BP       = 23,
  parameter bit         HSYNC_POL  = 1'b1,
  parameter bit         VSYNC_POL  = 1'b1,
  parameter int         CLKDIV     = 1,
  parameter int         RECTBITS   = 6,
  parameter int         RBITS      = 3,
  parameter int         GBITS      = 3,
  parameter int         BBITS      = 2,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic             clk,
  input  logic             rst_b,
  vga_rect_unit_if.slave   vg,
  output logic             Hsync,
  output logic             Vsync,
  output logic [RBITS-1:0] vgaRed,
  output logic [GBITS-1:0] vgaGreen,
  output logic [BBITS-1:0] vgaBlue
);

  localparam int NRECT     = 2 ** RECTBITS;
  localparam int COLORBITS = RBITS + GBITS + BBITS;
  localparam int STAGES    = 2;

  logic                  tick, visible, hs_act, vs_act, vblank, swap;
  logic [WIDTHBITS-1:0]  x;
  logic [HEIGHTBITS-1:0] y;
  logic [FIELD_W-1:0]    x12, y12;
  logic [RECTBITS-1:0]   widx;
  logic [NRECT-1:0]      hit, hit_q;
  logic [NRECT-1:0][7:0] rect_color;
  logic [STAGES:0]       vld_pipe, hs_pipe, vs_pipe;
  logic [7:0]            sel_color, color_q, pix;

  vga_timing #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WIDTHBITS(WIDTHBITS), .HEIGHTBITS(HEIGHTBITS),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CLKDIV(CLKDIV)
  ) u_timing (
    .clk(clk), .rst_b(rst_b), .tick(tick), .x(x), .y(y), .visible(visible),
    .hs_act(hs_act), .vs_act(vs_act), .vblank(vblank), .swap(swap)
  );

  assign vg.vg__vblank = vblank;
  assign vg.vg__frame  = swap;

  assign x12  = FIELD_W'(x);
  assign y12  = FIELD_W'(y);
  assign widx = vg.vg__addr[RECTBITS:1];

  // Each lane owns its shadow/active pair; the swap copies the write-merged shadow
  // so a store on the swap clk lands in the new active bank.
  for (genvar i = 0; i < NRECT; i++) begin : g_rect
    rect_t shadow_q, active_q, shadow_nxt;

    always_comb begin
      shadow_nxt = shadow_q;
      if (vg.vg__write && (widx == RECTBITS'(i))) begin
        if (!vg.vg__addr[0]) begin
          shadow_nxt.color = vg.vg__data[W0_COLOR_LSB +: 8];
          shadow_nxt.x1    = vg.vg__data[W0_X1_LSB +: FIELD_W];
          shadow_nxt.x0    = vg.vg__data[W0_X0_LSB +: FIELD_W];
        end else begin
          shadow_nxt.en    = vg.vg__data[W1_EN_BIT];
          shadow_nxt.y1    = vg.vg__data[W1_Y1_LSB +: FIELD_W];
          shadow_nxt.y0    = vg.vg__data[W1_Y0_LSB +: FIELD_W];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_nxt;
        if (swap) active_q <= shadow_nxt;
      end
    end

    assign hit[i] = active_q.en &&
                    (x12 >= active_q.x0) && (x12 <= active_q.x1) &&
                    (y12 >= active_q.y0) && (y12 <= active_q.y1);
    assign rect_color[i] = active_q.color;
  end

  assign vld_pipe[0] = visible;
  assign hs_pipe[0]  = hs_act;
  assign vs_pipe[0]  = vs_act;

`ifdef VGA_TEST_PATTERN_EN
  logic [WIDTHBITS-1:0] x_q;
  logic [WIDTHBITS+2:0] x_scaled;
  logic [2:0]           bar;
  logic [7:0]           bar_color;

  assign x_scaled  = {x_q, 3'b000};
  assign bar       = 3'(x_scaled / (WIDTHBITS+3)'(WIDTH));
  assign bar_color = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)    x_q <= '0;
    else if (tick) x_q <= x;
  end
`endif

  // Descending scan so the lowest hitting index is the last assignment.
  always_comb begin
    sel_color = BG_COLOR;
    for (int i = NRECT - 1; i >= 0; i--)
      if (hit_q[i]) sel_color = rect_color[i];
`ifdef VGA_TEST_PATTERN_EN
    if (vg.vg__pattern) sel_color = bar_color;
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_pipe[STAGES:1] <= '0;
      hs_pipe[STAGES:1]  <= '0;
      vs_pipe[STAGES:1]  <= '0;
      hit_q              <= '0;
      color_q            <= '0;
    end else if (tick) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      hs_pipe[STAGES:1]  <= hs_pipe[STAGES-1:0];
      vs_pipe[STAGES:1]  <= vs_pipe[STAGES-1:0];
      hit_q              <= hit;
      color_q            <= sel_color;
    end
  end

  assign pix      = vld_pipe[STAGES] ? color_q : 8'h00;
  assign vgaRed   = RBITS'(color_field(pix, COLORBITS - 1, RBITS));
  assign vgaGreen = GBITS'(color_field(pix, COLORBITS - 1 - RBITS, GBITS));
  assign vgaBlue  = BBITS'(color_field(pix, BBITS - 1, BBITS));
  assign Hsync    = hs_pipe[STAGES] ? HSYNC_POL : !HSYNC_POL;
  assign Vsync    = vs_pipe[STAGES] ? VSYNC_POL : !VSYNC_POL;

endmodule

// File: tb/tb_vga_rect_unit.sv
// Directed bench for vga_rect_unit: 16x8 raster (22x11 total), 4 rects, CLKDIV 1 and 2.
// Pattern checks run only when VGA_TEST_PATTERN_EN is defined.
module tb_vga_rect_unit;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  vga_rect_unit_if #(.RECTBITS(2)) vg_if ();
  vga_rect_unit_if #(.RECTBITS(2)) vg2_if ();

  logic       hs, vs, hs2, vs2;
  logic [2:0] red, green, red2, green2;
  logic [1:0] blue, blue2;

  vga_rect_unit #(
    .WIDTH(16), .HEIGHT(8), .WIDTHBITS(5), .HEIGHTBITS(4),
    .H_FP(2), .H_SYNC(2), .H_BP(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLKDIV(1), .RECTBITS(2),
    .RBITS(3), .GBITS(3), .BBITS(2), .BG_COLOR(8'h00)
  ) u_dut (
    .clk(clk), .rst_b(rst_b), .vg(vg_if), .Hsync(hs), .Vsync(vs),
    .vgaRed(red), .vgaGreen(green), .vgaBlue(blue)
  );

  vga_rect_unit #(
    .WIDTH(16), .HEIGHT(8), .WIDTHBITS(5), .HEIGHTBITS(4),
    .H_FP(2), .H_SYNC(2), .H_BP(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLKDIV(2), .RECTBITS(2),
    .RBITS(3), .GBITS(3), .BBITS(2), .BG_COLOR(8'h00)
  ) u_dut2 (
    .clk(clk), .rst_b(rst_b), .vg(vg2_if), .Hsync(hs2), .Vsync(vs2),
    .vgaRed(red2), .vgaGreen(green2), .vgaBlue(blue2)
  );

  // Clock edges since reset release; with CLKDIV=1 this equals the raster position.
  int cnt;
  always @(posedge clk or negedge rst_b)
    if (!rst_b) cnt <= 0;
    else        cnt <= cnt + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_cnt(input int t);
    int guard;
    guard = 0;
    while (cnt < t && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (cnt != t) begin
      checks++;
      failures++;
      $display("FAIL wait observed cnt=%0d expected cnt=%0d", cnt, t);
    end
  endtask

  // Pins show pixel (x,y) of frame f two clks after the counter held it.
  task automatic at_pix(input int f, input int x, input int y);
    at_cnt(f * 242 + y * 22 + x + 2);
  endtask

  task automatic wr(input logic [1:0] idx, input logic word, input logic [31:0] data);
    vg_if.vg__addr  = {idx, word};
    vg_if.vg__data  = data;
    vg_if.vg__write = 1'b1;
    @(negedge clk);
    vg_if.vg__write = 1'b0;
  endtask

  task automatic wr_rect(input logic [1:0] idx, input logic [7:0] color,
                         input int x0, input int x1, input int y0, input int y1, input logic en);
    wr(idx, 1'b0, {color, 12'(x1), 12'(x0)});
    wr(idx, 1'b1, {en, 7'd0, 12'(y1), 12'(y0)});
  endtask

  initial begin
    rst_b = 1'b0;
    vg_if.vg__write  = 1'b0; vg_if.vg__data  = '0; vg_if.vg__addr  = '0;
    vg2_if.vg__write = 1'b0; vg2_if.vg__data = '0; vg2_if.vg__addr = '0;
`ifdef VGA_TEST_PATTERN_EN
    vg_if.vg__pattern = 1'b0; vg2_if.vg__pattern = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rgb", {red, green, blue}, 8'h00);
    chk("rst_hsync", hs, 1'b0);
    chk("rst_vsync", vs, 1'b0);
    chk("rst_vblank", vg_if.vg__vblank, 1'b0);
    chk("rst_frame", vg_if.vg__frame, 1'b0);
    chk("rst_div2_rgb", {red2, green2, blue2}, 8'h00);
    chk("rst_div2_hsync", hs2, 1'b0);
    rst_b = 1'b1;

    // Frame 0: empty banks, sync placement
    at_cnt(19);      chk("hs_x17", hs, 1'b0);
    at_cnt(20);      chk("hs_x18", hs, 1'b1);
    at_cnt(21);      chk("hs_x19", hs, 1'b1);
    at_cnt(22);      chk("hs_x20", hs, 1'b0);
    at_cnt(39);      chk("div2_hs_pre", hs2, 1'b0);
    at_cnt(40);      chk("div2_hs_on", hs2, 1'b1);
    at_cnt(42);      chk("hs_line1", hs, 1'b1);
    at_cnt(43);      chk("div2_hs_held", hs2, 1'b1);
    at_cnt(44);      chk("div2_hs_off", hs2, 1'b0);
    at_pix(0, 3, 2); chk("empty_rgb", {red, green, blue}, 8'h00);
    wr_rect(2'd0, 8'hE0, 2, 5, 1, 3, 1'b1);
    at_pix(0, 2, 3); chk("shadow_only", {red, green, blue}, 8'h00);
    at_cnt(83);      chk("div2_hs_l1_pre", hs2, 1'b0);
    at_cnt(84);      chk("div2_hs_l1_on", hs2, 1'b1);
    at_cnt(175);     chk("frame_pulse", vg_if.vg__frame, 1'b1);
                     chk("vblank_pre", vg_if.vg__vblank, 1'b0);
    at_cnt(176);     chk("frame_end", vg_if.vg__frame, 1'b0);
                     chk("vblank_on", vg_if.vg__vblank, 1'b1);
    at_pix(0, 0, 8); chk("vs_y8", vs, 1'b0);
    at_pix(0, 0, 9); chk("vs_y9", vs, 1'b1);
    at_pix(0, 0, 10); chk("vs_y10", vs, 1'b0);

    // Frame 1: rect0 live, edges inclusive
    at_pix(1, 3, 0); chk("r0_above", {red, green, blue}, 8'h00);
    at_pix(1, 1, 1); chk("r0_left", {red, green, blue}, 8'h00);
    at_pix(1, 2, 1); chk("r0_x0", {red, green, blue}, 8'hE0);
    at_pix(1, 5, 1); chk("r0_x1", {red, green, blue}, 8'hE0);
    at_pix(1, 6, 1); chk("r0_right", {red, green, blue}, 8'h00);
    at_pix(1, 3, 3); chk("r0_y1", {red, green, blue}, 8'hE0);
    at_pix(1, 3, 4); chk("r0_below", {red, green, blue}, 8'h00);
    wr_rect(2'd1, 8'h03, 4, 8, 1, 3, 1'b1);
    at_cnt(417);     chk("frame_pulse_f1", vg_if.vg__frame, 1'b1);
    at_pix(1, 0, 9); chk("vs_period", vs, 1'b1);

    // Frame 2: overlap priority, then mid-frame rewrite of rect0
    at_pix(2, 3, 2); chk("ovl_r0_only", {red, green, blue}, 8'hE0);
    at_pix(2, 4, 2); chk("ovl_r0_wins", {red, green, blue}, 8'hE0);
    at_pix(2, 5, 2); chk("ovl_r0_edge", {red, green, blue}, 8'hE0);
    at_pix(2, 6, 2); chk("ovl_r1", {red, green, blue}, 8'h03);
    at_pix(2, 8, 2); chk("ovl_r1_x1", {red, green, blue}, 8'h03);
    at_pix(2, 9, 2); chk("ovl_none", {red, green, blue}, 8'h00);
    wr(2'd0, 1'b0, {8'h1C, 12'd5, 12'd2});
    at_pix(2, 3, 3); chk("midframe_hold", {red, green, blue}, 8'hE0);
    at_pix(2, 4, 3); chk("midframe_hold2", {red, green, blue}, 8'hE0);

    // Frame 3: rewrite visible; then store on the swap clk itself
    at_pix(3, 3, 2); chk("rewrite_shown", {red, green, blue}, 8'h1C);
    at_pix(3, 4, 2); chk("rewrite_prio", {red, green, blue}, 8'h1C);
    at_cnt(901);     chk("frame_pulse_f3", vg_if.vg__frame, 1'b1);
    wr(2'd0, 1'b0, {8'h02, 12'd5, 12'd2});

    // Frame 4: merged swap write, then inverted and edge-of-screen rects
    at_pix(4, 3, 2); chk("swap_merge", {red, green, blue}, 8'h02);
    at_pix(4, 6, 2); chk("swap_r1", {red, green, blue}, 8'h03);
    wr_rect(2'd2, 8'hFF, 6, 3, 0, 7, 1'b1);
    wr_rect(2'd3, 8'hFF, 10, 20, 6, 6, 1'b1);

    // Frame 5
    at_pix(5, 3, 5);  chk("inv_x3", {red, green, blue}, 8'h00);
    at_pix(5, 4, 5);  chk("inv_x4", {red, green, blue}, 8'h00);
    at_pix(5, 6, 5);  chk("inv_x6", {red, green, blue}, 8'h00);
    at_pix(5, 9, 6);  chk("r3_left", {red, green, blue}, 8'h00);
    at_pix(5, 10, 6); chk("r3_x0", {red, green, blue}, 8'hFF);
    at_pix(5, 15, 6); chk("r3_last_vis", {red, green, blue}, 8'hFF);

    // Asynchronous reset in the middle of the line
    #2 rst_b = 1'b0;
    #1;
    chk("arst_rgb", {red, green, blue}, 8'h00);
    chk("arst_hsync", hs, 1'b0);
    chk("arst_vblank", vg_if.vg__vblank, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    at_cnt(19);      chk("rst2_hs_x17", hs, 1'b0);
    at_cnt(20);      chk("rst2_hs_x18", hs, 1'b1);
    at_pix(0, 3, 2); chk("rst2_active_clr", {red, green, blue}, 8'h00);
    at_pix(1, 3, 2); chk("rst2_shadow_clr", {red, green, blue}, 8'h00);

`ifdef VGA_TEST_PATTERN_EN
    vg_if.vg__pattern = 1'b1;
    at_pix(2, 0, 1);  chk("pat_bar0", {red, green, blue}, 8'h00);
    at_pix(2, 4, 1);  chk("pat_bar2", {red, green, blue}, 8'h1C);
    at_pix(2, 6, 1);  chk("pat_bar3", {red, green, blue}, 8'h1F);
    at_pix(2, 15, 1); chk("pat_bar7", {red, green, blue}, 8'hFF);
    at_pix(2, 18, 1); chk("pat_hsync", hs, 1'b1);
                      chk("pat_blank", {red, green, blue}, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
